fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch controller for the IF stage of the five-stage MIPS pipeline. It owns the fetch PC and sequences single-outstanding requests to the instruction memory port. It holds each returned instruction in an output register until decode accepts it, and handles branch/exception redirects, including discarding a response that is already in flight.

## Interface

- RESET_PC, 32'h00400000, fetch address after reset.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode cannot accept; output holds while if_valid=1.
- redirect_valid  in  1  flush and restart fetch at redirect_pc; highest priority.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00).
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word-aligned request address; stable while imem_req=1 unless redirected.
- imem_gnt  in  1  memory accepted request this cycle (valid only with imem_req=1).
- imem_rvalid  in  1  read data returned this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_pc/if_instr hold a valid fetch.
- if_pc  out  32  address of if_instr.
- if_instr  out  32  fetched instruction.

## Operation

- Registers: state, fetch_pc[31:0], and the output register (if_valid, if_pc, if_instr).
- Reset: state=REQ, fetch_pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0.
- Combinational outputs: imem_req=1 only in REQ. imem_addr=fetch_pc in all states.
- REQ:
  - gnt → WAIT.
  - no gnt → stay in REQ.
- WAIT:
  - rvalid → capture if_instr=rdata, if_pc=fetch_pc, if_valid=1; fetch_pc+=4 (mod 2^32, wraps 0xFFFFFFFC→0); → HOLD.
- HOLD:
  - if_valid=1 and !stall (consumed) → if_valid=0, → REQ.
  - stall → stay; outputs frozen.
- DROP (response owed for a killed request):
  - rvalid → discard data, → REQ.
  - otherwise stay.
- Redirect (any state): fetch_pc=redirect_pc & ~3 and if_valid=0. Redirect overrides stall and any capture. Next state:
  - from REQ with gnt same cycle → DROP (old-address request was accepted).
  - from REQ without gnt → REQ (new address presented next cycle).
  - from WAIT with rvalid same cycle → REQ (data discarded).
  - from WAIT without rvalid → DROP.
  - from HOLD → REQ.
  - from DROP with rvalid → REQ.
  - from DROP without rvalid → DROP (fetch_pc still updated).
- rvalid in REQ or HOLD is spurious and ignored. gnt outside REQ is ignored.
- At most one outstanding request. The output register is always empty in REQ, WAIT and DROP.

## Timing

- Reset release: imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
- Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): if_valid rises 2 cycles after the REQ cycle. Peak throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect in cycle N: if_valid=0 in N+1. Without a pending response, imem_req=1 with imem_addr=redirect_pc in N+1.
- Reset asserted mid-operation: all state returns to reset values next cycle. No response is awaited, and the memory side is reset together with this block.

## Structure

- Shared package mips_pkg holds:
  - fetch_state_t enum (REQ, WAIT, HOLD, DROP), 2-bit encoding.
  - RESET_PC_DEFAULT constant 32'h00400000.
  - INSTR_BYTES constant 4.
- Single flat module; no sub-module. The output register is small enough to stay inline.

## Test plan

- Reset then memory with gnt=1 and rvalid one cycle later, stall=0 → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; each if_valid pulse carries the matching if_pc and rdata.
- Stall held 4 cycles while in HOLD with if_instr=0x8C220004 → if_valid, if_pc and if_instr constant and imem_req=0 throughout; REQ for 0x00400004 follows release.
- Redirect to 0x00400100 while in WAIT, rvalid 3 cycles later → that rdata is never presented; next imem_addr=0x00400100 and if_pc=0x00400100.
- Redirect in the same cycle as gnt in REQ → DROP, then a single rvalid is discarded, then the request goes to the redirect address. Redirect with rvalid in WAIT → REQ directly, no DROP.
- Redirect to 0xFFFFFFFE → fetch at 0xFFFFFFFC, then the next fetch wraps to 0x00000000. Redirect and stall together in HOLD → if_valid=0 next cycle.
- Reset asserted during WAIT → next cycle if_valid=0 and state REQ with imem_addr=0x00400000; a late rvalid arriving in REQ is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch state encoding
// and the architectural constants the IF stage depends on.
package mips_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: single-outstanding instruction memory requests,
// an output register held until decode accepts, and redirect/flush handling.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic         if_valid_reg, if_valid_next;
  logic [31:0]  if_pc_reg, if_pc_next;
  logic [31:0]  if_instr_reg, if_instr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= REQ;
      fetch_pc_reg <= RESET_PC;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= RESET_PC;
      if_instr_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if_valid_reg <= if_valid_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;

    case (state_reg)
      REQ: begin
        if (imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if_instr_next = imem_rdata;
          if_pc_next    = fetch_pc_reg;
          if_valid_next = 1'b1;
          fetch_pc_next = fetch_pc_reg + INSTR_BYTES;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (if_valid_reg && !stall) begin
          if_valid_next = 1'b0;
          state_next    = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = REQ;
    endcase

    // A redirect wins over everything; an accepted-but-unanswered request
    // must still be drained through DROP so its response is not mistaken.
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ~32'd3;
      if_valid_next = 1'b0;
      if_pc_next    = if_pc_reg;
      if_instr_next = if_instr_reg;
      case (state_reg)
        REQ:     state_next = imem_gnt    ? DROP : REQ;
        WAIT:    state_next = imem_rvalid ? REQ  : DROP;
        HOLD:    state_next = REQ;
        DROP:    state_next = imem_rvalid ? REQ  : DROP;
        default: state_next = REQ;
      endcase
    end
  end

  assign imem_req  = (state_reg == REQ);
  assign imem_addr = fetch_pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_instr  = if_instr_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a behavioural memory, a scoreboard of the
// expected architectural fetch stream, and a monitor that checks every hand-off.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam int          NCYC      = 3000;
  localparam int          WRAP_CYC  = 800;
  localparam int          RST_AFTER = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  bit run_active = 1'b0;
  bit saw_wrap = 1'b0;

  // Expected next instruction address in program order.
  logic [31:0] exp_q[$];

  // Memory contents: a fixed scramble of the address, so stale data is visible.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8C22_0004;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver + memory model ----------------
  initial begin
    bit          outstanding;
    int          delay;
    logic [31:0] pend_addr;
    bit          chk_redir_req;
    logic [31:0] chk_addr;
    bit          chk_reset;
    bit          rst_done;
    int          quiet_until;
    bit          rv, g, rd;
    logic [31:0] tgt;

    outstanding = 0; delay = 0; pend_addr = 0;
    chk_redir_req = 0; chk_addr = 0; chk_reset = 1; rst_done = 0; quiet_until = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_active = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        #1;
      end

      if (chk_reset) begin
        check(if_valid == 1'b0, "reset_if_valid", {31'd0, if_valid}, 32'd0);
        check(imem_req == 1'b1, "reset_imem_req", {31'd0, imem_req}, 32'd1);
        check(imem_addr == RESET_PC, "reset_imem_addr", imem_addr, RESET_PC);
        check(if_pc == RESET_PC, "reset_if_pc", if_pc, RESET_PC);
        check(if_instr == 32'd0, "reset_if_instr", if_instr, 32'd0);
        chk_reset = 0;
      end
      if (chk_redir_req) begin
        check(imem_req == 1'b1, "redirect_req", {31'd0, imem_req}, 32'd1);
        check(imem_addr == chk_addr, "redirect_addr", imem_addr, chk_addr);
        chk_redir_req = 0;
      end
      if (imem_req) begin
        check(!outstanding, "single_outstanding", {31'd0, outstanding}, 32'd0);
        check(imem_addr[1:0] == 2'b00, "addr_aligned", imem_addr, imem_addr & ~32'd3);
      end

      // Reset pulse while a response is still owed; memory resets alongside.
      if (!rst_done && cyc >= RST_AFTER && outstanding) begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        outstanding = 0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        rst_done = 1; chk_reset = 1;
        $display("cyc %0d: reset asserted mid-fetch", cyc);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        chk_reset = 0;
        check(if_valid == 1'b0, "midrst_if_valid", {31'd0, if_valid}, 32'd0);
        check(imem_req == 1'b1, "midrst_imem_req", {31'd0, imem_req}, 32'd1);
        check(imem_addr == RESET_PC, "midrst_imem_addr", imem_addr, RESET_PC);
      end

      // Response side: real response after its latency, or an occasional
      // spurious pulse when nothing is owed (must be ignored).
      rv = 0;
      if (outstanding) begin
        if (delay == 0) begin
          rv = 1; imem_rdata = mem_fn(pend_addr);
        end else begin
          delay--;
        end
      end else if ($urandom % 12 == 0) begin
        rv = 1; imem_rdata = $urandom;
      end

      g  = imem_req && ($urandom % 3 != 0);
      stall = ($urandom % 3 == 0);
      rd = (cyc >= quiet_until) && ($urandom % 20 == 0);
      tgt = 32'h0040_0000 + ($urandom_range(0, 255) * 4) + ($urandom % 4);
      if (cyc == WRAP_CYC) begin
        rd = 1; tgt = 32'hFFFF_FFFE; quiet_until = cyc + 60;
      end

      if (rd) begin
        exp_q.delete();
        exp_q.push_back(tgt & ~32'd3);
        chk_redir_req = (!outstanding || rv) && !g;
        chk_addr = tgt & ~32'd3;
        $display("cyc %0d: redirect to 0x%08h", cyc, tgt);
      end

      imem_rvalid    = rv;
      imem_gnt       = g;
      redirect_valid = rd;
      redirect_pc    = tgt;

      if (rv && outstanding) outstanding = 0;
      if (g) begin
        outstanding = 1;
        pend_addr   = imem_addr;
        delay       = $urandom_range(0, 2);
      end
    end

    @(posedge clk);
    #1;
    run_active = 1'b0;
    check(consumed >= 100, "throughput", consumed, 32'd100);
    check(saw_wrap, "wrap_to_zero", {31'd0, saw_wrap}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_redir = 0;
  bit          prev_hold  = 0;
  logic [31:0] prev_pc    = 0;
  logic [31:0] prev_instr = 0;
  logic [31:0] last_pc    = 0;
  int          idle_cyc   = 0;

  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (!run_active || reset) begin
      prev_redir = 0; prev_hold = 0; idle_cyc = 0;
    end else begin
      if (prev_redir)
        check(if_valid == 1'b0, "redirect_flush", {31'd0, if_valid}, 32'd0);
      if (prev_hold) begin
        check(if_valid == 1'b1, "stall_valid", {31'd0, if_valid}, 32'd1);
        check(if_pc == prev_pc, "stall_pc", if_pc, prev_pc);
        check(if_instr == prev_instr, "stall_instr", if_instr, prev_instr);
      end
      if (if_valid)
        check(imem_req == 1'b0, "no_req_while_full", {31'd0, imem_req}, 32'd0);

      if (if_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_output", if_pc, 32'd0);
        end else begin
          exp_pc = exp_q.pop_front();
          check(if_pc == exp_pc, "if_pc", if_pc, exp_pc);
          check(if_instr == mem_fn(exp_pc), "if_instr", if_instr, mem_fn(exp_pc));
          exp_q.push_back(exp_pc + 32'd4);
          $display("consume pc=0x%08h instr=0x%08h", if_pc, if_instr);
          if (last_pc == 32'hFFFF_FFFC && if_pc == 32'd0) saw_wrap = 1'b1;
          last_pc = if_pc;
        end
        consumed++;
        idle_cyc = 0;
      end else begin
        idle_cyc++;
        if (idle_cyc > 200) begin
          check(1'b0, "progress_timeout", idle_cyc, 32'd200);
          idle_cyc = 0;
        end
      end

      prev_redir = redirect_valid;
      prev_hold  = if_valid && stall && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
  end

endmodule
